eth_rx_frame_parser: RTL

//  Sits directly downstream of the 64-bit AXIS receive source and upstream of the Ethernet top's RX input.

---
 rtl/eth_pkg.sv | 25 ++
 rtl/eth_rx_frame_parser_if.sv | 11 +
 rtl/eth_keep_decode.sv | 15 +
 rtl/eth_rx_frame_parser.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared constants, FSM encoding and tkeep helper for the Ethernet RX frame parser.
package eth_pkg;
  localparam int          ETH_DATA_W    = 64;
  localparam int          ETH_KEEP_W    = 8;
  localparam int          ETH_HDR_BYTES = 14;
  localparam logic [47:0] ETH_BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    S_FIRST = 2'd0,
    S_HDR   = 2'd1,
    S_BODY  = 2'd2,
    S_DROP  = 2'd3
  } eth_state_t;

  // Non-last beats must be full; a last beat must be a non-empty run of low bytes.
  function automatic logic keep_legal(input logic [7:0] keep, input logic last);
    logic ok;
    ok = 1'b0;
    if (!last) ok = (keep == 8'hFF);
    else
      for (int n = 1; n <= 8; n++)
        if (keep == 8'((9'd1 << n) - 9'd1)) ok = 1'b1;
    return ok;
  endfunction
endpackage

// File: rtl/eth_rx_frame_parser_if.sv
// 64-bit AXI-stream beat bundle without back-pressure.
interface eth_rx_frame_parser_if;
  import eth_pkg::*;
  logic                  tvalid;
  logic [ETH_DATA_W-1:0] tdata;
  logic                  tlast;
  logic [ETH_KEEP_W-1:0] tkeep;

  modport master (output tvalid, tdata, tlast, tkeep);
  modport slave  (input  tvalid, tdata, tlast, tkeep);
endinterface

// File: rtl/eth_keep_decode.sv
// tkeep -> valid byte count and "contiguous from byte 0" flag.
module eth_keep_decode
  import eth_pkg::*;
(
  input  logic [7:0] i_keep,
  output logic [3:0] o_cnt,
  output logic       o_contig
);
  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < 8; i++) o_cnt = o_cnt + 4'(i_keep[i]);
  end

  assign o_contig = keep_legal(i_keep, 1'b1);
endmodule

// File: rtl/eth_rx_frame_parser.sv
// Ethernet RX header parser / MAC filter: forwards accepted frames with one
// cycle of latency and reports per-frame header, status and counters.
module eth_rx_frame_parser
  import eth_pkg::*;
#(
  parameter logic [47:0] P_LOCAL_MAC = 48'h211abcdef112,
  parameter int          P_MIN_BYTES = 60,
  parameter int          P_MAX_BYTES = 1514,
  parameter bit          P_PROMISC   = 1'b0
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  eth_rx_frame_parser_if.slave        rx_axis,
  eth_rx_frame_parser_if.master       tx_axis,
  output logic                        o_hdr_valid,
  output logic [47:0]                 o_dst_mac,
  output logic [47:0]                 o_src_mac,
  output logic [15:0]                 o_ethertype,
  output logic                        o_frame_done,
  output logic [15:0]                 o_frame_len,
  output logic                        o_err_runt,
  output logic                        o_err_long,
  output logic                        o_err_keep,
  output logic                        o_frame_dropped,
  output logic [31:0]                 o_cnt_ok,
  output logic [31:0]                 o_cnt_drop
);
  localparam logic [15:0] L_MIN = 16'(P_MIN_BYTES);
  localparam logic [15:0] L_MAX = 16'(P_MAX_BYTES);

  eth_state_t  r_state, w_state_nxt;
  logic        w_fwd, w_match, w_first, w_drop_frame;
  logic        r_second;
  logic [15:0] r_len, w_len_base, w_len_sat;
  logic [16:0] w_len_sum;
  logic        r_kerr, w_kerr, w_keep_ok;
  logic [3:0]  w_cnt;
  logic        w_contig;
  logic [47:0] w_dst;
  logic [63:0] w_d;

  eth_keep_decode u_keep (
    .i_keep   (rx_axis.tkeep),
    .o_cnt    (w_cnt),
    .o_contig (w_contig)
  );

  assign w_d     = rx_axis.tdata;
  assign w_dst   = {w_d[7:0], w_d[15:8], w_d[23:16], w_d[31:24], w_d[39:32], w_d[47:40]};
  assign w_match = P_PROMISC || (w_dst == P_LOCAL_MAC) || (w_dst == ETH_BCAST_MAC);
  assign w_first = rx_axis.tvalid && (r_state == S_FIRST);

  assign w_keep_ok  = rx_axis.tlast ? w_contig : (rx_axis.tkeep == 8'hFF);
  assign w_kerr     = (w_first ? 1'b0 : r_kerr) | ~w_keep_ok;
  assign w_len_base = w_first ? 16'd0 : r_len;
  assign w_len_sum  = {1'b0, w_len_base} + 17'(w_cnt);
  assign w_len_sat  = w_len_sum[16] ? 16'hFFFF : w_len_sum[15:0];

  // The drop decision for a single-beat frame is only known combinationally.
  assign w_drop_frame = (r_state == S_FIRST) ? ~w_match : (r_state == S_DROP);

  always_comb begin
    w_state_nxt = r_state;
    w_fwd       = 1'b0;
    if (rx_axis.tvalid) begin
      unique case (r_state)
        S_FIRST: begin
          w_fwd = w_match;
          if (!rx_axis.tlast) w_state_nxt = w_match ? S_HDR : S_DROP;
        end
        S_HDR: begin
          w_fwd       = 1'b1;
          w_state_nxt = rx_axis.tlast ? S_FIRST : S_BODY;
        end
        S_BODY: begin
          w_fwd = 1'b1;
          if (rx_axis.tlast) w_state_nxt = S_FIRST;
        end
        S_DROP: begin
          if (rx_axis.tlast) w_state_nxt = S_FIRST;
        end
        default: w_state_nxt = S_FIRST;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_FIRST;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tx_axis.tvalid  <= 1'b0;
      tx_axis.tdata   <= '0;
      tx_axis.tlast   <= 1'b0;
      tx_axis.tkeep   <= '0;
      o_hdr_valid     <= 1'b0;
      o_dst_mac       <= '0;
      o_src_mac       <= '0;
      o_ethertype     <= '0;
      o_frame_done    <= 1'b0;
      o_frame_len     <= '0;
      o_err_runt      <= 1'b0;
      o_err_long      <= 1'b0;
      o_err_keep      <= 1'b0;
      o_frame_dropped <= 1'b0;
      o_cnt_ok        <= '0;
      o_cnt_drop      <= '0;
      r_second        <= 1'b0;
      r_len           <= '0;
      r_kerr          <= 1'b0;
    end else begin
      tx_axis.tvalid <= w_fwd;
      if (w_fwd) begin
        tx_axis.tdata <= rx_axis.tdata;
        tx_axis.tlast <= rx_axis.tlast;
        tx_axis.tkeep <= rx_axis.tkeep;
      end
      o_hdr_valid  <= rx_axis.tvalid && (r_state == S_HDR);
      o_frame_done <= rx_axis.tvalid && rx_axis.tlast;

      if (rx_axis.tvalid) begin
        r_len  <= w_len_sat;
        r_kerr <= w_kerr;
        if (w_first) begin
          o_dst_mac         <= w_dst;
          o_src_mac[47:32]  <= {w_d[55:48], w_d[63:56]};
          r_second          <= ~rx_axis.tlast;
        end else begin
          r_second <= 1'b0;
        end
        // Header capture runs for dropped frames too; only hdr_valid is gated.
        if (r_second) begin
          o_src_mac[31:0] <= {w_d[7:0], w_d[15:8], w_d[23:16], w_d[31:24]};
          o_ethertype     <= {w_d[39:32], w_d[47:40]};
        end
        if (rx_axis.tlast) begin
          o_frame_len     <= w_len_sat;
          o_err_runt      <= (w_len_sat < L_MIN);
          o_err_long      <= (w_len_sat > L_MAX);
          o_err_keep      <= w_kerr;
          o_frame_dropped <= w_drop_frame;
          if (w_drop_frame) o_cnt_drop <= o_cnt_drop + 32'd1;
          else              o_cnt_ok   <= o_cnt_ok + 32'd1;
        end
      end
    end
  end
endmodule
